// File: rtl/mult_div_unit_if.sv
// ============================================================================
// Module      : mult_div_unit_if
// Description : Issue/result bundle between the core and the multiply/divide unit.
//               Div0 exists only when MDU_DIV0_FLAG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
`ifdef MDU_DIV0_FLAG_EN
  logic             Div0;
`endif

  modport master (
    output Start, Op, SrcA, SrcB,
`ifdef MDU_DIV0_FLAG_EN
    input  Div0,
`endif
    input  Busy, Done, HI, LO
  );

  modport slave (
    input  Start, Op, SrcA, SrcB,
`ifdef MDU_DIV0_FLAG_EN
    output Div0,
`endif
    output Busy, Done, HI, LO
  );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative WIDTH-cycle multiply/divide unit with HI/LO registers.
//               Optional divide-by-zero flag output under MDU_DIV0_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic     CLK,
  input  wire logic     RST,
  mult_div_unit_if.slave mdu
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_acc;   // partial product upper half / partial remainder
  logic [WIDTH-1:0] r_q;     // multiplier being consumed / quotient being built
  logic [WIDTH-1:0] r_opnd;  // multiplicand / divisor magnitude
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;

  // Operand decode and magnitude conversion at issue
  logic             w_md_op;
  logic             w_op_div;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_md_op  = ~mdu.Op[2];
  assign w_op_div = mdu.Op[1];
  assign w_signed = ~mdu.Op[0];
  assign w_a_neg  = w_signed & mdu.SrcA[WIDTH-1];
  assign w_b_neg  = w_signed & mdu.SrcB[WIDTH-1];
  assign w_b_zero = (mdu.SrcB == '0);
  assign w_a_mag  = w_a_neg ? -mdu.SrcA : mdu.SrcA;
  assign w_b_mag  = w_b_neg ? -mdu.SrcB : mdu.SrcB;

  // One shift-add multiply step
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH-1:0] w_mul_q;

  assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_acc = w_mul_sum[WIDTH:1];
  assign w_mul_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};

  // One restoring divide step; a zero divisor always "fits", giving all-ones quotient
  logic [WIDTH:0]   w_div_t;
  logic [WIDTH:0]   w_div_diff;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_div_acc;
  logic [WIDTH-1:0] w_div_q;

  assign w_div_t    = {r_acc, r_q[WIDTH-1]};
  assign w_div_diff = w_div_t - {1'b0, r_opnd};
  assign w_div_ok   = ~w_div_diff[WIDTH];
  assign w_div_acc  = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_t[WIDTH-1:0];
  assign w_div_q    = {r_q[WIDTH-2:0], w_div_ok};

  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]   w_q_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_fin_hi;
  logic [WIDTH-1:0]   w_fin_lo;

  assign w_acc_nxt  = r_is_div ? w_div_acc : w_mul_acc;
  assign w_q_nxt    = r_is_div ? w_div_q   : w_mul_q;
  assign w_prod     = {w_acc_nxt, w_q_nxt};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_fin_hi   = r_is_div ? (r_neg_r ? -w_acc_nxt : w_acc_nxt) : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_fin_lo   = r_is_div ? (r_neg_q ? -w_q_nxt   : w_q_nxt)   : w_prod_fix[WIDTH-1:0];

`ifdef MDU_DIV0_FLAG_EN
  logic r_b_zero;
  logic r_div0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_b_zero <= 1'b0;
      r_div0   <= 1'b0;
    end else if (r_state == c_CALC) begin
      if (r_cnt == c_LAST) begin
        r_div0 <= r_is_div & r_b_zero;
      end
    end else if (mdu.Start) begin
      if (w_md_op) begin
        r_b_zero <= w_b_zero;
      end else if (!mdu.Op[1]) begin
        r_div0 <= 1'b0;
      end
    end
  end

  assign mdu.Div0 = r_div0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= c_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      case (r_state)
        c_CALC: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == c_LAST) begin
            r_hi    <= w_fin_hi;
            r_lo    <= w_fin_lo;
            r_state <= c_DONE;
          end
        end
        default: begin
          r_state <= c_IDLE;
          if (mdu.Start) begin
            if (w_md_op) begin
              r_state  <= c_CALC;
              r_cnt    <= '0;
              r_acc    <= '0;
              r_is_div <= w_op_div;
              if (w_op_div) begin
                // Divide by zero keeps the raw dividend and skips sign correction
                r_q     <= w_b_zero ? mdu.SrcA : w_a_mag;
                r_opnd  <= w_b_mag;
                r_neg_q <= (w_a_neg ^ w_b_neg) & ~w_b_zero;
                r_neg_r <= w_a_neg & ~w_b_zero;
              end else begin
                r_q     <= w_b_mag;
                r_opnd  <= w_a_mag;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= 1'b0;
              end
            end else if (!mdu.Op[1]) begin
              if (mdu.Op[0]) begin
                r_lo <= mdu.SrcA;
              end else begin
                r_hi <= mdu.SrcA;
              end
            end
          end
        end
      endcase
    end
  end

  assign mdu.Busy = (r_state == c_CALC);
  assign mdu.Done = (r_state == c_DONE);
  assign mdu.HI   = r_hi;
  assign mdu.LO   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Scoreboard bench for mult_div_unit against a 64-bit arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mult_div_unit_if #(.WIDTH(W)) mdu();
  mult_div_unit #(.WIDTH(W)) dut (.CLK(CLK), .RST(RST), .mdu(mdu));

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         d0;
  } exp_t;

  exp_t         expq[$];
  exp_t         mon_e;
  int           n_checks = 0;
  int           n_fail   = 0;
  int           busy_cnt = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_d0 = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results from plain wide arithmetic
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output exp_t e);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    e.d0 = 1'b0;
    case (op)
      3'd0: begin sp = sa * sb; e.hi = sp[63:32]; e.lo = sp[31:0]; end
      3'd1: begin up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; end
      default: begin
        if (b == '0) begin
          e.hi = a; e.lo = '1; e.d0 = 1'b1;
        end else if (op == 3'd2) begin
          sp = sa / sb; e.lo = sp[31:0];
          sp = sa % sb; e.hi = sp[31:0];
        end else begin
          up = ua / ub; e.lo = up[31:0];
          up = ua % ub; e.hi = up[31:0];
        end
      end
    endcase
  endtask

  // Monitor: compares every Done cycle against the head of the scoreboard
  always @(negedge CLK) begin
    if (RST) begin
      busy_cnt = 0;
    end else begin
      if (mdu.Done) begin
        if (expq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got Done=1 expected no pending result at %0t", $time);
        end else begin
          mon_e = expq.pop_front();
          check("result_hi", mdu.HI, mon_e.hi);
          check("result_lo", mdu.LO, mon_e.lo);
          check("busy_cycles", busy_cnt, W);
`ifdef MDU_DIV0_FLAG_EN
          check("div0_flag", mdu.Div0, mon_e.d0);
`endif
        end
        busy_cnt = 0;
      end
      if (mdu.Busy) busy_cnt++;
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (mdu.Busy && k < 200) begin
      @(posedge CLK); #1;
      k++;
    end
    if (mdu.Busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_timeout: got Busy=1 expected 0 within 200 cycles");
    end
  endtask

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    wait_idle();
    mdu.Start = 1'b1;
    mdu.Op    = op;
    mdu.SrcA  = a;
    mdu.SrcB  = b;
    if (op < 3'd4) begin
      model(op, a, b, e);
      expq.push_back(e);
      m_hi = e.hi; m_lo = e.lo; m_d0 = e.d0;
    end else if (op == 3'd4) begin
      m_hi = a; m_d0 = 1'b0;
    end else if (op == 3'd5) begin
      m_lo = a; m_d0 = 1'b0;
    end
    @(posedge CLK); #1;
    mdu.Start = 1'b0;
    if (op < 3'd4) begin
      check("busy_after_issue", mdu.Busy, 1);
    end else begin
      check("idle_hi", mdu.HI, m_hi);
      check("idle_lo", mdu.LO, m_lo);
      check("idle_busy", mdu.Busy, 0);
      check("idle_done", mdu.Done, 0);
`ifdef MDU_DIV0_FLAG_EN
      check("idle_div0", mdu.Div0, m_d0);
`endif
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] hi_prev;
    mdu.Start = 1'b0;
    mdu.Op    = 3'd7;
    mdu.SrcA  = '0;
    mdu.SrcB  = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    check("reset_hi", mdu.HI, 0);
    check("reset_lo", mdu.LO, 0);
    check("reset_busy", mdu.Busy, 0);
    check("reset_done", mdu.Done, 0);

    // Reset mid-calculation discards the result
    do_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) begin @(posedge CLK); #1; end
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    expq.delete();
    m_hi = '0; m_lo = '0; m_d0 = 1'b0;
    check("abort_hi", mdu.HI, 0);
    check("abort_lo", mdu.LO, 0);
    check("abort_busy", mdu.Busy, 0);
    check("abort_done", mdu.Done, 0);
    do_op(3'd5, 32'h5, 32'h0);

    // Start during Busy must be ignored
    hi_prev = m_hi;
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) begin @(posedge CLK); #1; end
    mdu.Start = 1'b1; mdu.Op = 3'd4; mdu.SrcA = 32'h1234;
    @(posedge CLK); #1;
    mdu.Start = 1'b0;
    check("ignored_start_hi", mdu.HI, hi_prev);
    check("ignored_start_busy", mdu.Busy, 1);

    do_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0007);
    do_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'd3, 32'h1234_5678, 32'h0);
    do_op(3'd2, 32'hFFFF_FFF9, 32'h0);
    do_op(3'd4, 32'h0000_0077, 32'h0);
    do_op(3'd3, 32'd100, 32'd7);
    do_op(3'd4, 32'hAA, 32'h0);   // issued in the DONE cycle
    do_op(3'd6, 32'hDEAD_BEEF, 32'h1);
    do_op(3'd7, 32'hDEAD_BEEF, 32'h1);

    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick());
    end

    wait_idle();
    repeat (3) begin @(posedge CLK); #1; end
    check("pending_results", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
